// File: rtl/input_conditioner.sv
// input_conditioner
//   Multi-channel conditioner for asynchronous external inputs. Each channel
//   goes through an N-stage synchronizer, a consecutive-sample debounce
//   filter and a rise/fall edge detector. All outputs are registered.
//
// Ports
//   clk          : single clock, all state on the rising edge
//   rst          : asynchronous active-high reset
//   en           : 1 = chains sample in, 0 = chains sample DEFAULT_DISABLED
//   in           : raw asynchronous inputs, one bit per channel
//   edge_mode    : event select 00 rise, 01 fall, 10 both, 11 none
//   level        : debounced level per channel
//   rise_pulse   : one-cycle pulse when level goes 0->1
//   fall_pulse   : one-cycle pulse when level goes 1->0
//   event_pulse  : rise/fall pulse gated by edge_mode
//   any_event    : OR of event_pulse, registered in the same cycle
module input_conditioner #(
  parameter int unsigned          CHANNELS         = 4,
  parameter int unsigned          SYNC_STAGES      = 2,
  parameter int unsigned          DEBOUNCE_CYCLES  = 16,
  parameter logic [CHANNELS-1:0]  DEFAULT_DISABLED = '0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic [CHANNELS-1:0] in,
  input  logic [1:0]          edge_mode,
  output logic [CHANNELS-1:0] level,
  output logic [CHANNELS-1:0] rise_pulse,
  output logic [CHANNELS-1:0] fall_pulse,
  output logic [CHANNELS-1:0] event_pulse,
  output logic                any_event
);

  localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    MODE_RISE = 2'b00,
    MODE_FALL = 2'b01,
    MODE_BOTH = 2'b10,
    MODE_NONE = 2'b11
  } mode_e;

  logic [CHANNELS-1:0] r_sync [SYNC_STAGES];
  logic [CW-1:0]       r_cnt  [CHANNELS];
  logic [CHANNELS-1:0] r_level;
  logic [CHANNELS-1:0] r_rise;
  logic [CHANNELS-1:0] r_fall;
  logic [CHANNELS-1:0] r_event;
  logic                r_any;

  logic [CHANNELS-1:0] w_din;
  logic [CHANNELS-1:0] w_s;
  logic [CW-1:0]       w_cnt_nxt [CHANNELS];
  logic [CHANNELS-1:0] w_level_nxt;
  logic [CHANNELS-1:0] w_rise_nxt;
  logic [CHANNELS-1:0] w_fall_nxt;
  logic [CHANNELS-1:0] w_event_nxt;
  logic                w_rise_en;
  logic                w_fall_en;

  assign w_din = en ? in : DEFAULT_DISABLED;
  assign w_s   = r_sync[SYNC_STAGES-1];

  assign w_rise_en = (edge_mode == MODE_RISE) || (edge_mode == MODE_BOTH);
  assign w_fall_en = (edge_mode == MODE_FALL) || (edge_mode == MODE_BOTH);

  // Synchronizer chains; stage 0 captures the enable-selected input.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned k = 0; k < SYNC_STAGES; k++) begin
        r_sync[k] <= DEFAULT_DISABLED;
      end
    end else begin
      r_sync[0] <= w_din;
      for (int unsigned k = 1; k < SYNC_STAGES; k++) begin
        r_sync[k] <= r_sync[k-1];
      end
    end
  end

  // Debounce: a matching sample discards the count; the level only flips
  // once the count has reached its maximum, so the counter never wraps.
  always_comb begin
    w_level_nxt = r_level;
    w_rise_nxt  = '0;
    w_fall_nxt  = '0;
    w_event_nxt = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      w_cnt_nxt[i] = '0;
      if (w_s[i] != r_level[i]) begin
        if (r_cnt[i] == CNT_MAX) begin
          w_level_nxt[i] = w_s[i];
          w_rise_nxt[i]  = w_s[i];
          w_fall_nxt[i]  = ~w_s[i];
          w_event_nxt[i] = (w_s[i] & w_rise_en) | (~w_s[i] & w_fall_en);
        end else begin
          w_cnt_nxt[i] = r_cnt[i] + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        r_cnt[i] <= '0;
      end
      r_level <= DEFAULT_DISABLED;
      r_rise  <= '0;
      r_fall  <= '0;
      r_event <= '0;
      r_any   <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        r_cnt[i] <= w_cnt_nxt[i];
      end
      r_level <= w_level_nxt;
      r_rise  <= w_rise_nxt;
      r_fall  <= w_fall_nxt;
      r_event <= w_event_nxt;
      r_any   <= |w_event_nxt;
    end
  end

  assign level       = r_level;
  assign rise_pulse  = r_rise;
  assign fall_pulse  = r_fall;
  assign event_pulse = r_event;
  assign any_event   = r_any;

endmodule

// File: tb/tb_input_conditioner.sv
module tb_input_conditioner;

  logic       clk;
  logic       rst;
  logic       en;
  logic [3:0] in;
  logic [1:0] mode;
  logic [3:0] level, rise, fall, evt;
  logic       any;

  logic       en1, in1;
  logic [1:0] mode1;
  logic       level1, rise1, fall1, evt1, any1;

  int n_tests = 0;
  int n_fail  = 0;

  input_conditioner u_dut (
    .clk(clk), .rst(rst), .en(en), .in(in), .edge_mode(mode),
    .level(level), .rise_pulse(rise), .fall_pulse(fall),
    .event_pulse(evt), .any_event(any)
  );

  // Minimal-latency variant: 3-stage sync, single-sample debounce, default 1.
  input_conditioner #(
    .CHANNELS(1), .SYNC_STAGES(3), .DEBOUNCE_CYCLES(1), .DEFAULT_DISABLED(1'b1)
  ) u_dut1 (
    .clk(clk), .rst(rst), .en(en1), .in(in1), .edge_mode(mode1),
    .level(level1), .rise_pulse(rise1), .fall_pulse(fall1),
    .event_pulse(evt1), .any_event(any1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [3:0] e_lvl, input logic [3:0] e_rise,
                           input logic [3:0] e_fall, input logic [3:0] e_evt, input logic e_any);
    check({tag, ".level"}, 32'(level), 32'(e_lvl));
    check({tag, ".rise"},  32'(rise),  32'(e_rise));
    check({tag, ".fall"},  32'(fall),  32'(e_fall));
    check({tag, ".event"}, 32'(evt),   32'(e_evt));
    check({tag, ".any"},   32'(any),   32'(e_any));
  endtask

  // Expected event gating for modes 00,01,10,11.
  logic [3:0] ev_on_rise;
  logic [3:0] ev_on_fall;

  initial begin
    ev_on_rise = 4'b0101;  // bit m set: mode m reports rises
    ev_on_fall = 4'b0110;  // bit m set: mode m reports falls
    rst = 1'b1; en = 1'b1; in = 4'b0000; mode = 2'b00;
    en1 = 1'b1; in1 = 1'b1; mode1 = 2'b10;

    // Reset state
    tick(3);
    check_all("reset", 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0);
    check("reset.level1", 32'(level1), 32'd1);
    check("reset.any1",   32'(any1),   32'd0);
    rst = 1'b0;
    tick(3);
    check_all("post_reset", 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0);

    // Basic rise on in[0], mode 00: update at edge 18
    in = 4'b0001;
    tick(17);
    check_all("rise0.e17", 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0);
    tick(1);
    check_all("rise0.e18", 4'b0001, 4'b0001, 4'b0000, 4'b0001, 1'b1);
    tick(1);
    check_all("rise0.e19", 4'b0001, 4'b0000, 4'b0000, 4'b0000, 1'b0);

    // Glitch of 15 cycles on in[1]: rejected
    in = 4'b0011;
    tick(15);
    in = 4'b0001;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      check_all("glitch15", 4'b0001, 4'b0000, 4'b0000, 4'b0000, 1'b0);
    end

    // 16 cycles high on in[1]: accepted at edge 18, then falls at edge 34
    in = 4'b0011;
    tick(16);
    in = 4'b0001;
    tick(1);
    check_all("hold16.e17", 4'b0001, 4'b0000, 4'b0000, 4'b0000, 1'b0);
    tick(1);
    check_all("hold16.e18", 4'b0011, 4'b0010, 4'b0000, 4'b0010, 1'b1);
    tick(15);
    check_all("hold16.e33", 4'b0011, 4'b0000, 4'b0000, 4'b0000, 1'b0);
    tick(1);
    check_all("hold16.e34", 4'b0001, 4'b0000, 4'b0010, 4'b0000, 1'b0);
    tick(1);
    check_all("hold16.e35", 4'b0001, 4'b0000, 4'b0000, 4'b0000, 1'b0);

    // Mode coverage on in[2]
    for (int m = 0; m < 4; m++) begin
      mode = 2'(m);
      in[2] = 1'b1;
      tick(17);
      check_all("mode.rise.e17", 4'b0001, 4'b0000, 4'b0000, 4'b0000, 1'b0);
      tick(1);
      check_all("mode.rise.e18", 4'b0101, 4'b0100, 4'b0000,
                ev_on_rise[m] ? 4'b0100 : 4'b0000, ev_on_rise[m]);
      tick(1);
      check_all("mode.rise.e19", 4'b0101, 4'b0000, 4'b0000, 4'b0000, 1'b0);
      in[2] = 1'b0;
      tick(17);
      check_all("mode.fall.e17", 4'b0101, 4'b0000, 4'b0000, 4'b0000, 1'b0);
      tick(1);
      check_all("mode.fall.e18", 4'b0001, 4'b0000, 4'b0100,
                ev_on_fall[m] ? 4'b0100 : 4'b0000, ev_on_fall[m]);
      tick(1);
      check_all("mode.fall.e19", 4'b0001, 4'b0000, 4'b0000, 4'b0000, 1'b0);
    end

    // Bring in[0] back low (mode 00: no event on fall)
    mode = 2'b00;
    in = 4'b0000;
    tick(17);
    check_all("drop0.e17", 4'b0001, 4'b0000, 4'b0000, 4'b0000, 1'b0);
    tick(1);
    check_all("drop0.e18", 4'b0000, 4'b0000, 4'b0001, 4'b0000, 1'b0);

    // Simultaneous rise on in[0] and in[3]
    in = 4'b1001;
    tick(17);
    check_all("simul.e17", 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0);
    tick(1);
    check_all("simul.e18", 4'b1001, 4'b1001, 4'b0000, 4'b1001, 1'b1);
    tick(1);
    check_all("simul.e19", 4'b1001, 4'b0000, 4'b0000, 4'b0000, 1'b0);

    // Drop en: chains fill with default 0, levels fall with normal pulses
    mode = 2'b01;
    en = 1'b0;
    tick(17);
    check_all("en_off.e17", 4'b1001, 4'b0000, 4'b0000, 4'b0000, 1'b0);
    tick(1);
    check_all("en_off.e18", 4'b0000, 4'b0000, 4'b1001, 4'b1001, 1'b1);
    tick(1);
    check_all("en_off.e19", 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0);
    in = 4'b0000;
    en = 1'b1;
    mode = 2'b00;
    tick(3);
    check_all("en_on", 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0);

    // Reset at count 10 of a pending rise; full latency after release
    in = 4'b0001;
    tick(12);
    check_all("mid.e12", 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0);
    rst = 1'b1;
    #1;
    check_all("mid.rst", 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0);
    tick(2);
    check_all("mid.rst_hold", 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0);
    rst = 1'b0;
    tick(17);
    check_all("mid.rel.e17", 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0);
    tick(1);
    check_all("mid.rel.e18", 4'b0001, 4'b0001, 4'b0000, 4'b0001, 1'b1);

    // Single-sample debounce, 3-stage sync: latency 4, default level 1
    check("d1.init.level", 32'(level1), 32'd1);
    in1 = 1'b0;
    tick(3);
    check("d1.fall.e3.level", 32'(level1), 32'd1);
    tick(1);
    check("d1.fall.e4.level", 32'(level1), 32'd0);
    check("d1.fall.e4.fall",  32'(fall1),  32'd1);
    check("d1.fall.e4.rise",  32'(rise1),  32'd0);
    check("d1.fall.e4.event", 32'(evt1),   32'd1);
    check("d1.fall.e4.any",   32'(any1),   32'd1);
    tick(1);
    check("d1.fall.e5.fall",  32'(fall1),  32'd0);
    check("d1.fall.e5.any",   32'(any1),   32'd0);
    en1 = 1'b0;
    tick(3);
    check("d1.en_off.e3.level", 32'(level1), 32'd0);
    tick(1);
    check("d1.en_off.e4.level", 32'(level1), 32'd1);
    check("d1.en_off.e4.rise",  32'(rise1),  32'd1);
    check("d1.en_off.e4.event", 32'(evt1),   32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
